// File: rtl/forward_hazard_unit.sv
// EX-stage forwarding selects and load-use / redirect hazard control, tracking an E/M/W tag pipe.
// Optional stall/flush statistics counters are compiled in with HAZARD_STATS_EN.
module forward_hazard_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  input  logic        regwrite_d,
  input  logic [1:0]  resultsrc_d,
  input  logic        pc_src_e,
  output logic [1:0]  forward_a_e,
  output logic [1:0]  forward_b_e,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
`endif
  output logic        flush_e
);

  localparam logic [1:0] FwdRegFile = 2'b00;
  localparam logic [1:0] FwdWb      = 2'b01;
  localparam logic [1:0] FwdMem     = 2'b10;
  localparam logic [1:0] SrcLoad    = 2'b01;

  logic [4:0] rs1_e_q, rs2_e_q, rd_e_q, rd_m_q, rd_w_q;
  logic [4:0] rs1_e_d, rs2_e_d, rd_e_d;
  logic       regwrite_e_q, regwrite_m_q, regwrite_w_q;
  logic       regwrite_e_d;
  logic [1:0] resultsrc_e_q, resultsrc_e_d;
  logic       lw_stall;

  // MEM is checked first so the newest producer wins; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       rw_m, input logic [4:0] rd_m,
                                         input logic       rw_w, input logic [4:0] rd_w);
    if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) return FwdMem;
    if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) return FwdWb;
    return FwdRegFile;
  endfunction

  always_comb begin
    forward_a_e = fwd_sel(rs1_e_q, regwrite_m_q, rd_m_q, regwrite_w_q, rd_w_q);
    forward_b_e = fwd_sel(rs2_e_q, regwrite_m_q, rd_m_q, regwrite_w_q, rd_w_q);
  end

  always_comb begin
    lw_stall = (resultsrc_e_q == SrcLoad) && (rd_e_q != 5'd0) &&
               ((rd_e_q == rs1_d) || (rd_e_q == rs2_d));
    stall_f  = lw_stall & ~pc_src_e;
    stall_d  = lw_stall & ~pc_src_e;
    flush_d  = pc_src_e;
    flush_e  = pc_src_e | lw_stall;
  end

  always_comb begin
    rs1_e_d       = rs1_d;
    rs2_e_d       = rs2_d;
    rd_e_d        = rd_d;
    regwrite_e_d  = regwrite_d;
    resultsrc_e_d = resultsrc_d;
    if (flush_e) begin
      rs1_e_d       = 5'd0;
      rs2_e_d       = 5'd0;
      rd_e_d        = 5'd0;
      regwrite_e_d  = 1'b0;
      resultsrc_e_d = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_e_q       <= 5'd0;
      rs2_e_q       <= 5'd0;
      rd_e_q        <= 5'd0;
      regwrite_e_q  <= 1'b0;
      resultsrc_e_q <= 2'b00;
      rd_m_q        <= 5'd0;
      regwrite_m_q  <= 1'b0;
      rd_w_q        <= 5'd0;
      regwrite_w_q  <= 1'b0;
    end else begin
      rs1_e_q       <= rs1_e_d;
      rs2_e_q       <= rs2_e_d;
      rd_e_q        <= rd_e_d;
      regwrite_e_q  <= regwrite_e_d;
      resultsrc_e_q <= resultsrc_e_d;
      rd_m_q        <= rd_e_q;
      regwrite_m_q  <= regwrite_e_q;
      rd_w_q        <= rd_m_q;
      regwrite_w_q  <= regwrite_m_q;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_q, flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      if (stall_d) stall_count_q <= stall_count_q + 32'd1;
      if (flush_d) flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit: directed scenarios plus randomized traffic
// compared against an instruction-history reference model.
module tb_forward_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       regwrite_d;
  logic [1:0] resultsrc_d;
  logic       pc_src_e;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, flush_d, flush_e;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count, flush_count;
`endif

  always #10 clk = ~clk;

  forward_hazard_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rd_d        (rd_d),
    .regwrite_d  (regwrite_d),
    .resultsrc_d (resultsrc_d),
    .pc_src_e    (pc_src_e),
    .forward_a_e (forward_a_e),
    .forward_b_e (forward_b_e),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
`ifdef HAZARD_STATS_EN
    .stall_count (stall_count),
    .flush_count (flush_count),
`endif
    .flush_e     (flush_e)
  );

  // {fa[7:6], fb[5:4], stall_f[3], stall_d[2], flush_d[1], flush_e[0]}
  logic [7:0] obs;
  assign obs = {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e};

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [4:0] rd;
    logic       rw;
    logic [1:0] src;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } instr_t;

  // Instruction history: index 0 is in EX, 1 in MEM, 2 in WB.
  instr_t      hist [3];
  int unsigned sc_m, fc_m;

  function automatic instr_t cur_d();
    instr_t i;
    i.rd = rd_d; i.rw = regwrite_d; i.src = resultsrc_d; i.rs1 = rs1_d; i.rs2 = rs2_d;
    return i;
  endfunction

  // Youngest older instruction writing the register supplies the value.
  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    for (int age = 1; age <= 2; age++)
      if (hist[age].rw && hist[age].rd == rs) return (age == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [7:0] model_out();
    logic lw;
    lw = (hist[0].src == 2'b01) && (hist[0].rd != 5'd0) &&
         ((hist[0].rd == rs1_d) || (hist[0].rd == rs2_d));
    return {model_fwd(hist[0].rs1), model_fwd(hist[0].rs2),
            lw && !pc_src_e, lw && !pc_src_e, pc_src_e, pc_src_e || lw};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) hist[i] = '0;
    sc_m = 0;
    fc_m = 0;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic [1:0] src, input logic pc);
    @(negedge clk);
    rs1_d = rs1; rs2_d = rs2; rd_d = rd; regwrite_d = rw; resultsrc_d = src; pc_src_e = pc;
    #1;
  endtask

  task automatic tick();
    logic [7:0] e;
    e = model_out();
    @(posedge clk);
    if (e[2]) sc_m++;
    if (e[1]) fc_m++;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = e[0] ? '0 : cur_d();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rs1_d = 5'd1; rs2_d = 5'd2; rd_d = 5'd1; regwrite_d = 1'b1; resultsrc_d = 2'b01;
    pc_src_e = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (obs !== 8'h00) begin
      $display("FAIL reset_outputs: got %b want %b", obs, 8'h00); n_fails++;
    end
`ifdef HAZARD_STATS_EN
    n_checks++;
    if ({stall_count, flush_count} !== 64'd0) begin
      $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_count, flush_count); n_fails++;
    end
`endif
    pc_src_e = 1'b1;
    #1;
    n_checks++;
    if (obs !== 8'b0000_0011) begin
      $display("FAIL reset_pc_src: got %b want %b", obs, 8'b0000_0011); n_fails++;
    end
    @(negedge clk);
    pc_src_e = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_ex_forward();
    drive(5'd0, 5'd0, 5'd5, 1'b1, 2'b00, 1'b0); tick();
    drive(5'd5, 5'd0, 5'd6, 1'b1, 2'b00, 1'b0); tick();
    drive(5'd5, 5'd0, 5'd8, 1'b1, 2'b00, 1'b0);
    n_checks++;
    if (forward_a_e !== 2'b10) begin
      $display("FAIL ex_fwd_mem: got %b want 10", forward_a_e); n_fails++;
    end
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
    n_checks++;
    if (forward_a_e !== 2'b01) begin
      $display("FAIL ex_fwd_wb: got %b want 01", forward_a_e); n_fails++;
    end
    n_checks++;
    if (obs !== model_out()) begin
      $display("FAIL ex_fwd_vec: got %b want %b", obs, model_out()); n_fails++;
    end
    tick();
  endtask

  task automatic test_double_match();
    drive(5'd0, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0); tick();
    drive(5'd0, 5'd7, 5'd0, 1'b0, 2'b00, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
    n_checks++;
    if (forward_b_e !== 2'b10) begin
      $display("FAIL double_match: got %b want 10", forward_b_e); n_fails++;
    end
    tick();
  endtask

  task automatic test_x0();
    drive(5'd0, 5'd0, 5'd0, 1'b1, 2'b00, 1'b0); tick();
    for (int c = 0; c < 3; c++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b1, 2'b00, 1'b0);
      n_checks++;
      if (forward_a_e !== 2'b00) begin
        $display("FAIL x0_no_fwd cycle %0d: got %b want 00", c, forward_a_e); n_fails++;
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    drive(5'd0, 5'd0, 5'd3, 1'b1, 2'b01, 1'b0); tick();
    drive(5'd0, 5'd3, 5'd4, 1'b1, 2'b00, 1'b0);
    n_checks++;
    if (obs !== 8'b0000_1101) begin
      $display("FAIL load_use_stall: got %b want %b", obs, 8'b0000_1101); n_fails++;
    end
    tick();
    drive(5'd0, 5'd3, 5'd4, 1'b1, 2'b00, 1'b0);
    n_checks++;
    if (obs[3:0] !== 4'b0000) begin
      $display("FAIL load_use_one_cycle: got %b want 0000", obs[3:0]); n_fails++;
    end
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
    n_checks++;
    if (forward_b_e !== 2'b01) begin
      $display("FAIL load_use_fwd_wb: got %b want 01", forward_b_e); n_fails++;
    end
    tick();
  endtask

  task automatic test_simultaneous();
    drive(5'd0, 5'd0, 5'd3, 1'b1, 2'b01, 1'b0); tick();
    drive(5'd3, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1);
    n_checks++;
    if (obs !== 8'b0000_0011) begin
      $display("FAIL simult_flush_prio: got %b want %b", obs, 8'b0000_0011); n_fails++;
    end
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
`ifdef HAZARD_STATS_EN
    n_checks++;
    if (stall_count !== sc_m || flush_count !== fc_m) begin
      $display("FAIL simult_counters: got %0d/%0d want %0d/%0d",
               stall_count, flush_count, sc_m, fc_m); n_fails++;
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive(5'd0, 5'd0, 5'd3, 1'b1, 2'b01, 1'b0); tick();
    drive(5'd0, 5'd3, 5'd0, 1'b0, 2'b00, 1'b0);
    n_checks++;
    if (obs !== 8'b0000_1101) begin
      $display("FAIL mid_stall_setup: got %b want %b", obs, 8'b0000_1101); n_fails++;
    end
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (obs !== 8'h00) begin
      $display("FAIL mid_stall_reset_async: got %b want %b", obs, 8'h00); n_fails++;
    end
`ifdef HAZARD_STATS_EN
    n_checks++;
    if ({stall_count, flush_count} !== 64'd0) begin
      $display("FAIL mid_stall_counters: got %0d/%0d want 0/0", stall_count, flush_count);
      n_fails++;
    end
`endif
    #1 rst_n = 1'b1;
    #1;
    n_checks++;
    if (obs !== 8'h00) begin
      $display("FAIL mid_stall_after_release: got %b want %b", obs, 8'h00); n_fails++;
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      n_checks++;
      if (obs !== model_out()) begin
        $display("FAIL random cycle %0d: got %b want %b", c, obs, model_out()); n_fails++;
      end
`ifdef HAZARD_STATS_EN
      n_checks++;
      if (stall_count !== sc_m || flush_count !== fc_m) begin
        $display("FAIL random_counters cycle %0d: got %0d/%0d want %0d/%0d",
                 c, stall_count, flush_count, sc_m, fc_m); n_fails++;
      end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_double_match();
    test_x0();
    test_load_use();
    test_simultaneous();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
